vx_gbar_unit: RTL



---
 rtl/vx_gbar_unit_pkg.sv | 20 ++
 rtl/vx_popcount.sv | 18 +
 rtl/vx_gbar_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vx_gbar_unit_pkg.sv
// Shared types and sizing for the global barrier responder.
// Barrier/core counts are fixed here; widths and request/response structs derive from them.
package vx_gbar_unit_pkg;

   localparam int NUM_BARRIERS = 8;
   localparam int NUM_CORES    = 16;
   localparam int NB_WIDTH     = $clog2(NUM_BARRIERS);
   localparam int NC_WIDTH     = $clog2(NUM_CORES);

   typedef struct packed {
      logic [NB_WIDTH-1:0] id;
      logic [NC_WIDTH-1:0] size_m1;
      logic [NC_WIDTH-1:0] core_id;
   } gbar_req_t;

   typedef struct packed {
      logic [NB_WIDTH-1:0] id;
   } gbar_rsp_t;

endpackage

// File: rtl/vx_popcount.sv
// Combinational population count of an N-bit vector.
// Zero latency, no flow control.
module vx_popcount #(
   parameter int N   = 16,
   parameter int C_W = $clog2(N + 1)
) (
   input  logic [N-1:0]   i_data,
   output logic [C_W-1:0] o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < N; i++) begin
         o_count = o_count + C_W'(i_data[i]);
      end
   end

endmodule

// File: rtl/vx_gbar_unit.sv
// Global barrier responder: collects core arrivals per barrier ID, pulses rsp on release.
// Release/error pulses arrive 1 cycle after acceptance; req_ready is high out of reset, rsp/err never stall.
module vx_gbar_unit
   import vx_gbar_unit_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic [NB_WIDTH-1:0] req_id,
   input  logic [NC_WIDTH-1:0] req_size_m1,
   input  logic [NC_WIDTH-1:0] req_core_id,
   output logic                req_ready,
   output logic                rsp_valid,
   output logic [NB_WIDTH-1:0] rsp_id,
   output logic                err_valid,
   output logic [NB_WIDTH-1:0] err_id,
   output logic                busy
);

   localparam int CNT_W = NC_WIDTH + 1;
   localparam int PC_W  = $clog2(NUM_CORES + 1);

   logic [NUM_BARRIERS-1:0] r_active;
   logic [NUM_CORES-1:0]    r_mask [NUM_BARRIERS];
   logic [NC_WIDTH-1:0]     r_size [NUM_BARRIERS];
   logic                    r_rsp_vld;
   logic                    r_err_vld;
   gbar_rsp_t               r_rsp;
   gbar_rsp_t               r_err;

   gbar_req_t               w_req;
   logic                    w_accept;
   logic [NUM_CORES-1:0]    w_onehot;
   logic [NUM_CORES-1:0]    w_cur_mask;
   logic [NUM_CORES-1:0]    w_new_mask;
   logic                    w_cur_act;
   logic [NC_WIDTH-1:0]     w_cur_size;
   logic [NC_WIDTH-1:0]     w_tgt_size;
   logic                    w_core_ok;
   logic                    w_dup;
   logic                    w_size_bad;
   logic                    w_err;
   logic                    w_good;
   logic [PC_W-1:0]         w_cnt;
   logic                    w_release;
   logic                    w_arrive;

   assign req_ready = ~reset;
   assign w_accept  = req_valid & req_ready;
   assign w_req     = '{id: req_id, size_m1: req_size_m1, core_id: req_core_id};

   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         w_onehot[i] = (CNT_W'(w_req.core_id) == CNT_W'(i));
      end
   end

   assign w_cur_mask = r_mask[w_req.id];
   assign w_cur_act  = r_active[w_req.id];
   assign w_cur_size = r_size[w_req.id];
   assign w_new_mask = w_cur_mask | w_onehot;

   // Out-of-range core IDs only exist when NUM_CORES is not a power of two.
   assign w_core_ok  = (CNT_W'(w_req.core_id) < CNT_W'(NUM_CORES));
   assign w_dup      = |(w_cur_mask & w_onehot);
   assign w_size_bad = w_cur_act && (w_req.size_m1 != w_cur_size);
   assign w_err      = w_accept & (~w_core_ok | w_size_bad | w_dup);
   assign w_good     = w_accept & ~(~w_core_ok | w_size_bad | w_dup);
   assign w_tgt_size = w_cur_act ? w_cur_size : w_req.size_m1;

   vx_popcount #(
      .N   (NUM_CORES),
      .C_W (PC_W)
   ) u_popcount (
      .i_data  (w_new_mask),
      .o_count (w_cnt)
   );

   // Compare in NC_WIDTH+1 bits so size_m1 = NUM_CORES-1 does not wrap.
   assign w_release = w_good && (CNT_W'(w_cnt) == (CNT_W'(w_tgt_size) + CNT_W'(1)));
   assign w_arrive  = w_good && !w_release;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_active  <= '0;
         r_rsp_vld <= 1'b0;
         r_err_vld <= 1'b0;
         r_rsp     <= '0;
         r_err     <= '0;
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            r_mask[b] <= '0;
            r_size[b] <= '0;
         end
      end else begin
         r_rsp_vld <= w_release;
         r_err_vld <= w_err;
         if (w_release) begin
            r_rsp.id           <= w_req.id;
            r_active[w_req.id] <= 1'b0;
            r_mask[w_req.id]   <= '0;
         end
         if (w_arrive) begin
            r_active[w_req.id] <= 1'b1;
            r_mask[w_req.id]   <= w_new_mask;
            if (!w_cur_act) begin
               r_size[w_req.id] <= w_req.size_m1;
            end
         end
         if (w_err) begin
            r_err.id <= w_req.id;
         end
      end
   end

   assign rsp_valid = r_rsp_vld;
   assign rsp_id    = r_rsp.id;
   assign err_valid = r_err_vld;
   assign err_id    = r_err.id;
   assign busy      = |r_active;

endmodule
